// File: rtl/radio_dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radio_dds_pkg
// Description : Shared constants and waveform selector type for the DDS
//               waveform-LUT loader.
// Revision    : 1.0 - initial release
// ============================================================================
package radio_dds_pkg;

    localparam int LUT_AW     = 12;   // LUT address width, depth = 2**LUT_AW
    localparam int DW         = 8;    // signed sample width
    localparam int UNITY_GAIN = 128;  // amplitude code giving a gain of 1.0

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_t;

endpackage
`default_nettype wire

// File: rtl/dds_quarter_sine_rom.sv
`default_nettype none
// ============================================================================
// Module      : dds_quarter_sine_rom
// Description : Quarter-wave sine table with 2**QW+1 entries (0..pi/2
//               inclusive) and a registered single-cycle read. Contents are
//               constants produced by an elaboration-time function.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_quarter_sine_rom #(
    parameter int QW       = 10,
    parameter int DW       = 8,
    parameter int SINE_AMP = 127
) (
    input  logic          clk,
    input  logic [QW:0]   i_addr,
    output logic [DW-1:0] o_data
);

    localparam int  c_DEPTH   = (1 << QW) + 1;
    localparam real c_HALF_PI = 1.5707963267948966;

    // round(SINE_AMP * sin(pi/2 * k / 2**QW)); all entries are non-negative
    function automatic logic [DW-1:0] f_sine_entry(input int k);
        real v;
        v = real'(SINE_AMP) * $sin(c_HALF_PI * real'(k) / real'(1 << QW));
        return DW'($rtoi(v + 0.5));
    endfunction

    logic [DW-1:0] w_rom [c_DEPTH];
    logic [DW-1:0] r_data;

    generate
        for (genvar k = 0; k < c_DEPTH; k++) begin : g_rom
            assign w_rom[k] = f_sine_entry(k);
        end
    endgenerate

    // Registered read: data appears one cycle after the address
    always_ff @(posedge clk) begin
        r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/dds_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : dds_lut_loader
// Description : Streams a full 2**LUT_AW-entry waveform table (sine, square,
//               triangle, sawtooth, scaled by an 8-bit gain) into the DDS
//               LUT config port as cfg/cfg_ce bytes, framed by cfg_reset.
//               Aborts cleanly if the DDS leaves the stopped state.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_lut_loader
    import radio_dds_pkg::*;
#(
    parameter int LUT_AW   = radio_dds_pkg::LUT_AW,
    parameter int DW       = radio_dds_pkg::DW,
    parameter int SINE_AMP = 127
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    wave_sel,
    input  logic [7:0]    amplitude,
    input  logic          dds_idle,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cfg_reset,
    output logic [DW-1:0] cfg,
    output logic          cfg_ce
);

    localparam int c_QW    = LUT_AW - 2;               // index bits within a quadrant
    localparam int c_TRI_W = DW - 1;                   // triangle ramp magnitude bits
    localparam int c_SHIFT = $clog2(UNITY_GAIN);       // gain fraction bits
    localparam int c_PW    = DW + 9;                   // sample x {0,amplitude} product width

    localparam logic        [c_QW:0]   c_Q_ADDR = {1'b1, {c_QW{1'b0}}};
    localparam logic signed [DW-1:0]   c_PEAK   = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [c_PW-1:0] c_Y_MAX  = c_PW'(2**(DW-1) - 1);
    localparam logic signed [c_PW-1:0] c_Y_MIN  = c_PW'(-(2**(DW-1)));

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CLR    = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_DRAIN  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  w_accept, w_refuse, w_abort, w_finish;

    logic [LUT_AW-1:0]     r_idx;
    logic                  r_drain;
    wave_t                 r_wave;
    logic [7:0]            r_amp;
    logic                  r_done, r_err, r_cfg_reset;

    logic [1:0]            w_quad;
    logic [c_QW-1:0]       w_q;
    logic [c_TRI_W-1:0]    w_tri;
    logic signed [DW-1:0]  w_tri_s;
    logic [c_QW:0]         w_rom_addr;
    logic [DW-1:0]         w_rom_data;
    logic signed [DW-1:0]  w_raw;

    logic                  r_s1_valid, r_s1_sine, r_s1_neg;
    logic signed [DW-1:0]  r_s1_raw;

    logic signed [DW-1:0]  w_rom_s, w_sample;
    logic signed [c_PW-1:0] w_samp_x, w_gain_x, w_prod, w_shift;
    logic [DW-1:0]         w_sat;
    logic [DW-1:0]         r_cfg;
    logic                  r_ce;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next state and the one-cycle events that drive done/err/cfg_reset
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_refuse     = 1'b0;
        w_abort      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    if (dds_idle) begin
                        w_accept     = 1'b1;
                        w_next_state = c_ST_CLR;
                    end else begin
                        w_refuse     = 1'b1;
                    end
                end
            end
            c_ST_CLR: begin
                if (!dds_idle) begin
                    w_abort      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else begin
                    w_next_state = c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (!dds_idle) begin
                    w_abort      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (r_idx == {LUT_AW{1'b1}}) begin
                    w_next_state = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (!dds_idle) begin
                    w_abort      = 1'b1;
                    w_next_state = c_ST_IDLE;
                end else if (r_drain) begin
                    w_finish     = 1'b1;
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Control pulses, table index and the load parameters latched at start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_drain     <= 1'b0;
            r_wave      <= WAVE_SINE;
            r_amp       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cfg_reset <= 1'b0;
        end else begin
            r_done      <= w_refuse | w_abort | w_finish;
            r_err       <= w_refuse | w_abort;
            r_cfg_reset <= w_accept;
            r_drain     <= (r_state == c_ST_DRAIN) && !r_drain;
            if (w_accept) begin
                r_wave <= wave_t'(wave_sel);
                r_amp  <= amplitude;
            end
            if (r_state == c_ST_CLR)
                r_idx <= '0;
            else if (r_state == c_ST_STREAM)
                r_idx <= r_idx + LUT_AW'(1);
        end
    end

    assign w_quad     = r_idx[LUT_AW-1 -: 2];
    assign w_q        = r_idx[c_QW-1:0];
    assign w_tri      = w_q[c_QW-1 -: c_TRI_W];
    assign w_tri_s    = {1'b0, w_tri};
    // Odd quadrants read the quarter table backwards; Q-q reaches the pi/2 entry
    assign w_rom_addr = r_idx[LUT_AW-2] ? (c_Q_ADDR - {1'b0, w_q}) : {1'b0, w_q};

    // Non-sine raw samples; sine comes through the ROM's own register
    always_comb begin
        w_raw = '0;
        case (r_wave)
            WAVE_SQUARE: w_raw = r_idx[LUT_AW-1] ? -c_PEAK : c_PEAK;
            WAVE_TRI: begin
                case (w_quad)
                    2'd0:    w_raw = w_tri_s;
                    2'd1:    w_raw = c_PEAK - w_tri_s;
                    2'd2:    w_raw = -w_tri_s;
                    default: w_raw = w_tri_s - c_PEAK;
                endcase
            end
            WAVE_SAW:    w_raw = r_idx[LUT_AW-1 -: DW];
            default:     w_raw = '0;
        endcase
    end

    dds_quarter_sine_rom #(
        .QW       (c_QW),
        .DW       (DW),
        .SINE_AMP (SINE_AMP)
    ) u_sine_rom (
        .clk    (clk),
        .i_addr (w_rom_addr),
        .o_data (w_rom_data)
    );

    // Stage 2 combinational: pick/sign the sample, apply gain, arithmetic shift
    assign w_rom_s  = w_rom_data;
    assign w_sample = r_s1_sine ? (r_s1_neg ? -w_rom_s : w_rom_s) : r_s1_raw;
    assign w_samp_x = {{(c_PW-DW){w_sample[DW-1]}}, w_sample};
    assign w_gain_x = {{(c_PW-8){1'b0}}, r_amp};
    assign w_prod   = w_samp_x * w_gain_x;
    assign w_shift  = w_prod >>> c_SHIFT;

    // Clamp the scaled sample into the signed DW-bit range
    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > c_Y_MAX)
            w_sat = c_Y_MAX[DW-1:0];
        else if (w_shift < c_Y_MIN)
            w_sat = c_Y_MIN[DW-1:0];
    end

    // Two-stage sample pipeline; an abort drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_raw   <= '0;
            r_s1_sine  <= 1'b0;
            r_s1_neg   <= 1'b0;
            r_cfg      <= '0;
            r_ce       <= 1'b0;
        end else begin
            r_s1_valid <= (r_state == c_ST_STREAM) && !w_abort;
            r_s1_raw   <= w_raw;
            r_s1_sine  <= (r_wave == WAVE_SINE);
            r_s1_neg   <= r_idx[LUT_AW-1];
            r_ce       <= r_s1_valid && !w_abort;
            if (r_s1_valid)
                r_cfg <= w_sat;
        end
    end

    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign cfg_reset = r_cfg_reset;
    assign cfg       = r_cfg;
    assign cfg_ce    = r_ce;

endmodule
`default_nettype wire

// File: tb/tb_dds_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_lut_loader
// Description : Self-checking bench for dds_lut_loader. Captures the cfg_ce
//               byte stream and compares it with a table computed from the
//               waveform definitions using real arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_lut_loader;

    localparam int  DEPTH = 4096;
    localparam real PI    = 3.14159265358979323846;

    logic       clk = 1'b0;
    logic       reset, start, dds_idle;
    logic [1:0] wave_sel;
    logic [7:0] amplitude;
    logic       busy, done, err, cfg_reset, cfg_ce;
    logic [7:0] cfg;

    int n_cmp = 0;
    int n_bad = 0;

    int got [DEPTH];
    int n_got, n_clr, clr_cyc, ce_first, ce_last, done_cyc;
    bit done_seen, err_seen, rst_hit;

    always #5 clk = ~clk;

    dds_lut_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .wave_sel  (wave_sel),
        .amplitude (amplitude),
        .dds_idle  (dds_idle),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_reset (cfg_reset),
        .cfg       (cfg),
        .cfg_ce    (cfg_ce)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected table entry n for waveform w and gain a
    function automatic int ref_byte(input int w, input int a, input int n);
        int  raw, quad, t, y;
        real s;
        quad = n / 1024;
        t    = (n % 1024) / 8;
        case (w)
            0: begin
                s   = 127.0 * $sin(2.0 * PI * real'(n) / real'(DEPTH));
                raw = (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
            end
            1: raw = (n < DEPTH / 2) ? 127 : -127;
            2: begin
                case (quad)
                    0:       raw = t;
                    1:       raw = 127 - t;
                    2:       raw = -t;
                    default: raw = t - 127;
                endcase
            end
            default: raw = (n / 16 < 128) ? n / 16 : n / 16 - 256;
        endcase
        y = $rtoi($floor(real'(raw * a) / 128.0));
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    // Issue start and follow the load until done, a reset point, or timeout
    task automatic run_load(input int w, input int a, input int drop_at,
                            input int rst_at, input bit noise);
        n_got = 0; n_clr = 0; clr_cyc = -1; ce_first = -1; ce_last = -1;
        done_cyc = -1; done_seen = 0; err_seen = 0; rst_hit = 0;
        wave_sel  = 2'(w);
        amplitude = 8'(a);
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (cfg_reset) begin
                n_clr++;
                clr_cyc = c;
            end
            if (cfg_ce) begin
                if (n_got < DEPTH) got[n_got] = $signed(cfg);
                if (ce_first < 0) ce_first = c;
                ce_last = c;
                n_got++;
                if (drop_at >= 0 && n_got == drop_at + 1) dds_idle = 1'b0;
            end
            if (done) begin
                done_seen = 1;
                err_seen  = err;
                done_cyc  = c;
                break;
            end
            if (rst_at >= 0 && n_got == rst_at) begin
                reset = 1'b1;
                tick();
                check("midreset_busy", int'(busy), 0);
                check("midreset_cfg_ce", int'(cfg_ce), 0);
                check("midreset_done", int'(done), 0);
                reset   = 1'b0;
                rst_hit = 1;
                break;
            end
            if (noise && busy) begin
                start     = ($urandom_range(0, 3) == 0);
                wave_sel  = 2'($urandom);
                amplitude = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        if (!rst_hit) check("load_finished", int'(done_seen), 1);
    endtask

    task automatic verify_table(input string tag, input int w, input int a, input int count);
        int bad, first;
        bad = 0; first = -1;
        for (int n = 0; n < count && n < DEPTH; n++) begin
            if (got[n] != ref_byte(w, a, n)) begin
                bad++;
                if (first < 0) first = n;
            end
        end
        check({tag, "_table_errs"}, bad, 0);
        if (first >= 0) check({tag, "_first_bad_byte"}, got[first], ref_byte(w, a, first));
    endtask

    task automatic verify_full(input string tag, input int w, input int a);
        check({tag, "_done"}, int'(done_seen), 1);
        check({tag, "_err"}, int'(err_seen), 0);
        check({tag, "_cfg_reset_cnt"}, n_clr, 1);
        check({tag, "_cfg_reset_cyc"}, clr_cyc, 0);
        check({tag, "_bytes"}, n_got, DEPTH);
        check({tag, "_first_ce_cyc"}, ce_first, 3);
        check({tag, "_ce_span"}, ce_last - ce_first + 1, DEPTH);
        check({tag, "_done_cyc"}, done_cyc, ce_last + 1);
        verify_table(tag, w, a, n_got);
    endtask

    initial begin
        int w, a;
        reset = 1'b1; start = 1'b0; dds_idle = 1'b1;
        wave_sel = 2'd0; amplitude = 8'd0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_cfg_reset", int'(cfg_reset), 0);
        check("rst_cfg_ce", int'(cfg_ce), 0);
        check("rst_cfg", int'(cfg), 0);
        reset = 1'b0;
        tick();

        // Unity-gain sine
        run_load(0, 128, -1, -1, 0);
        verify_full("sine128", 0, 128);
        check("sine_b0", got[0], 0);
        check("sine_b1024", got[1024], 127);
        check("sine_b2048", got[2048], 0);
        check("sine_b3072", got[3072], -127);

        // Saturating square, started in the done cycle, with start noise while busy
        run_load(1, 255, -1, -1, 1);
        verify_full("square255", 1, 255);
        check("square_b0", got[0], 127);
        check("square_b2047", got[2047], 127);
        check("square_b2048", got[2048], -128);
        check("square_b4095", got[4095], -128);

        // Half-gain sawtooth
        run_load(3, 64, -1, -1, 0);
        verify_full("saw64", 3, 64);
        check("saw_b0", got[0], 0);
        check("saw_b2047", got[2047], 63);
        check("saw_b2048", got[2048], -64);
        check("saw_b4095", got[4095], -1);

        // Refused start: DDS running
        tick();
        dds_idle = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("refuse_done", int'(done), 1);
        check("refuse_err", int'(err), 1);
        check("refuse_busy", int'(busy), 0);
        check("refuse_cfg_reset", int'(cfg_reset), 0);
        tick();
        check("refuse_done_clear", int'(done), 0);
        check("refuse_cfg_reset2", int'(cfg_reset), 0);
        check("refuse_cfg_ce", int'(cfg_ce), 0);
        dds_idle = 1'b1;
        tick();

        // Abort at stream byte 100, then a full reload
        w = int'($urandom_range(0, 3));
        a = int'($urandom_range(0, 255));
        run_load(w, a, 100, -1, 0);
        dds_idle = 1'b1;
        check("abort_done", int'(done_seen), 1);
        check("abort_err", int'(err_seen), 1);
        check("abort_bytes", n_got, 101);
        check("abort_done_cyc", done_cyc, ce_last + 1);
        verify_table("abort_partial", w, a, n_got);
        run_load(w, a, -1, -1, 0);
        verify_full("after_abort", w, a);

        // Reset in the middle of a stream, then a full reload
        w = int'($urandom_range(0, 3));
        a = int'($urandom_range(0, 255));
        run_load(w, a, -1, 500, 0);
        check("midreset_taken", int'(rst_hit), 1);
        run_load(w, a, -1, -1, 0);
        verify_full("after_reset", w, a);

        // Randomized loads with start noise while busy
        for (int i = 0; i < 3; i++) begin
            w = int'($urandom_range(0, 3));
            a = (i == 0) ? 0 : int'($urandom_range(0, 255));
            run_load(w, a, -1, -1, 1);
            verify_full($sformatf("rand%0d_w%0d_a%0d", i, w, a), w, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
